// File: rtl/uart_pkg.sv
// Shared UART definitions: tx FSM state encoding, oversampling factor,
// default frame/baud constants shared by the tx framer and the receiver.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    // Oversampling ticks per start/data/parity bit.
    localparam int OVERSAMPLE = 16;

    // Defaults shared by the transmit and receive paths.
    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;
    localparam int DEF_CLK_DIV = 163;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    // Counter width for a modulus of n (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: tick pulses once every CLK_DIV clk cycles.
// Ports: clk, reset (async, active high), clr (sync restart), tick (out).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = idx_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // clr restarts the period so the first tick lands exactly CLK_DIV
    // cycles later; with CLK_DIV=1 the counter sits at 0 and ticks always.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) & ~clr;

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DBIT data bits LSB first, optional even
// parity (macro UART_TX_PARITY_EN), then SB_TICK ticks of stop on tx.
// Ports: clk, reset (async, active high), tx_start/din (request + word),
// tx_ready (accepting, IDLE only), tx (serial line, idle high),
// tx_busy (frame in flight), tx_done_tick (last cycle of stop bit).
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_ready,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int BW = idx_width(DBIT);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DBIT - 1);
    localparam logic [4:0]    BIT_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);

    tx_state_t       state;
    logic [4:0]      tcnt;
    logic [BW-1:0]   bidx;
    logic [DBIT-1:0] shreg;
    logic [DBIT-1:0] shreg_nxt;
    logic            accept;
    logic            tick;
    logic            bit_end;
    logic            stop_end;
`ifdef UART_TX_PARITY_EN
    logic            par;
`endif

    assign accept    = tx_start & tx_ready;
    assign shreg_nxt = shreg >> 1;
    assign bit_end   = tick & (tcnt == BIT_LAST);
    assign stop_end  = tick & (tcnt == STOP_LAST);

    // Restarting the divider on acceptance keeps every frame phase-aligned
    // to its own start bit, independent of when the request arrived.
    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .tick  (tick)
    );

    // Done is decoded from the last stop tick so it coincides with the
    // final stop-bit cycle; the FSM is back in IDLE one cycle later.
    assign tx_done_tick = (state == ST_STOP) & stop_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tcnt     <= '0;
            bidx     <= '0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (accept) begin
                        state    <= ST_START;
                        tx       <= 1'b0;
                        shreg    <= din;
                        tcnt     <= '0;
                        bidx     <= '0;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        par      <= ^din;
`endif
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        state <= ST_DATA;
                        tcnt  <= '0;
                        tx    <= shreg[0];
                    end else if (tick) begin
                        tcnt <= tcnt + 5'd1;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        tcnt  <= '0;
                        shreg <= shreg_nxt;
                        if (bidx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            tx    <= par;
`else
                            state <= ST_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bidx <= bidx + 1'b1;
                            tx   <= shreg_nxt[0];
                        end
                    end else if (tick) begin
                        tcnt <= tcnt + 5'd1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state <= ST_STOP;
                        tcnt  <= '0;
                        tx    <= 1'b1;
                    end else if (tick) begin
                        tcnt <= tcnt + 5'd1;
                    end
                end
`endif

                ST_STOP: begin
                    tx <= 1'b1;
                    if (stop_end) begin
                        state    <= ST_IDLE;
                        tcnt     <= '0;
                        bidx     <= '0;
                        tx_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                    end else if (tick) begin
                        tcnt <= tcnt + 5'd1;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                    tcnt     <= '0;
                    bidx     <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Transmit-side UART framer: the counterpart to the existing UART receive path.
- Accepts one parallel word per valid/ready handshake and serialises it as start bit, DBIT data bits LSB first, optional parity bit, then stop bits on `tx`.
- Contains its own 16x oversampling baud tick generator, so it needs no external `s_tick`.
- Sits between the transmit FIFO read side and the serial pin in the `uart` top level.

Parameters:
- DBIT, 8, number of data bits per frame.
- SB_TICK, 16, stop-bit length in oversampling ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- CLK_DIV, 163, clk cycles per oversampling tick (baud = f_clk / (16*CLK_DIV)); legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_start  input  1  valid: word on din requests transmission.
- din  input  DBIT  parallel data, sampled only on acceptance.
- tx_ready  output  1  high only in IDLE; acceptance = tx_start & tx_ready.
- tx  output  1  serial line, idle high, registered.
- tx_busy  output  1  high from the cycle after acceptance to the end of the stop bit.
- tx_done_tick  output  1  one-cycle pulse in the final cycle of the stop bit.

Behaviour:
- Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done_tick=0, state=IDLE, baud counter=0, tick counter=0, bit index=0.
- Baud generator:
  - Counter runs 0..CLK_DIV-1 and pulses `tick` when it reaches CLK_DIV-1.
  - It is cleared synchronously on acceptance, so every frame starts phase-aligned.
  - CLK_DIV=1 gives a tick every cycle.
- FSM states: IDLE, START, DATA, PARITY (only when the feature is enabled), STOP.
- IDLE:
  - tx=1.
  - On acceptance, latch din into the shift register, clear the tick and bit counters, and go to START.
- START:
  - tx=0.
  - After 16 ticks, go to DATA.
- DATA:
  - tx = shift[0].
  - After 16 ticks, shift right. Advance the bit index; after bit DBIT-1, go to PARITY or STOP.
- PARITY: tx = parity bit for 16 ticks, then go to STOP.
- STOP:
  - tx=1 for SB_TICK ticks.
  - On the final tick, pulse tx_done_tick and return to IDLE.
- Timing:
  - Every start, data and parity bit lasts exactly 16*CLK_DIV cycles. The stop bit lasts SB_TICK*CLK_DIV cycles.
  - The start bit (tx low) begins in the cycle after acceptance. No jitter is allowed.
  - Without parity, frame length = (16*(1+DBIT) + SB_TICK)*CLK_DIV cycles.
- Back-to-back frames: tx_ready rises in the cycle after tx_done_tick, so the minimum gap is one idle-high cycle beyond the stop bit.
- tx_start while not ready is ignored: no queueing, and din is not sampled.
- din changing after acceptance has no effect on the current frame.
- Reset mid-frame: tx returns high immediately (asynchronously) and the frame is abandoned. No tx_done_tick is generated.
- Counters: the tick counter is 5 bits (it must hold SB_TICK-1 up to 31), and the bit index is ceil(log2(DBIT)) bits.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - The PARITY state is compiled in. The parity bit is the XOR of the latched data bits (even parity) and is sent for 16 ticks between the last data bit and stop.
  - Frame length grows by 16*CLK_DIV cycles.
- When undefined: there is no PARITY state or logic, and STOP follows the last data bit directly.

Decomposition:
- Shared package `uart_pkg`:
  - State encoding typedef for the tx FSM.
  - OVERSAMPLE=16 constant.
  - Default DBIT, SB_TICK and CLK_DIV constants, shared with the receiver.
- Sub-module `uart_baud_gen`:
  - Ports: clk, reset, clr, tick.
  - Parameter: CLK_DIV.
  - Reusable later by the receiver in place of its `s_tick` hookup.

Test Plan:
- Reset then idle, DBIT=8, SB_TICK=16, CLK_DIV=4: tx=1, tx_ready=1, tx_busy=0 held for 1000 cycles with no tx_start.
- Single frame din=8'hA5, parity off:
  - tx low for cycles 1-64 after acceptance, then data bits 1,0,1,0,0,1,0,1, 64 cycles each, then high for 64 cycles.
  - tx_done_tick in cycle 640, tx_ready=1 in cycle 641.
- Back-to-back 8'h00 then 8'hFF:
  - tx_start held continuously; the second acceptance occurs in the cycle after tx_done_tick.
  - Exactly one idle-high cycle separates the frames, and bit timing matches the single-frame case.
- Busy-ignore: pulse tx_start with din=8'h3C at cycle 100 of an 8'hA5 frame. The line output matches 8'hA5 only, with a single tx_done_tick.
- Reset mid-frame: assert reset at cycle 300 of an 8'h55 frame. tx=1 immediately, with no tx_done_tick. A subsequent 8'h55 frame is fully correct.
- UART_TX_PARITY_EN defined, din=8'h07:
  - A parity bit of 1 is sent for 64 cycles after bit 7.
  - Frame length is 704 cycles; tx_done_tick occurs in cycle 704.
